// File: rtl/note_scheduler.sv
// note_scheduler: chart playback controller for the note highway.
// Divides CLOCK_50 into eighth-note step ticks, walks a step counter through
// a synchronous chart ROM and presents each step's lane mask as a registered
// note with a one-cycle valid pulse. Supports start/stop/pause/loop control.
// Optional build macro COUNTIN_EN: start first plays COUNTIN_STEPS count-in
// ticks (no ROM reads) before chart step 0.
module note_scheduler #(
  parameter int TICK_DIV      = 13157895,
  parameter int STEP_W        = 9,
  parameter int SONG_LEN      = 304,
  parameter int COUNTIN_STEPS = 8
) (
  input  logic              CLOCK_50,
  input  logic              resetn,
  input  logic              start,
  input  logic              stop,
  input  logic              pause,
  input  logic              loop,
  output logic [STEP_W-1:0] rom_addr,
  input  logic [4:0]        rom_data,
  output logic [4:0]        notes,
  output logic              note_valid,
  output logic [STEP_W-1:0] step,
  output logic              tick,
  output logic [2:0]        state,
  output logic              song_done
);

  localparam int DIV_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int CIN_W = (COUNTIN_STEPS > 1) ? $clog2(COUNTIN_STEPS + 1) : 1;
  localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(TICK_DIV - 1);
  localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(SONG_LEN - 1);
  localparam logic [CIN_W-1:0]  CIN_LAST  = CIN_W'(COUNTIN_STEPS - 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_COUNTIN = 3'd1,
    S_PLAY    = 3'd2,
    S_PAUSE   = 3'd3,
    S_DONE    = 3'd4
  } state_t;

`ifdef COUNTIN_EN
  localparam state_t START_ST = S_COUNTIN;
`else
  localparam state_t START_ST = S_PLAY;
`endif

  state_t             st;
  state_t             resume_st;
  state_t             run_next;
  logic [DIV_W-1:0]   divider;
  logic [CIN_W-1:0]   cin_cnt;
  logic               rd_pending;
  logic               end_pending;
  logic               running;

  // The ROM is addressed directly by the step counter; tick is decoded from
  // the divider so it lines up with the cycle the ROM samples the address.
  assign running  = (st == S_PLAY) || (st == S_COUNTIN);
  assign tick     = running && (divider == DIV_LAST) && !end_pending;
  assign rom_addr = step;
  assign state    = st;

  // Where a running state would go this cycle if pause were not asserted;
  // also the state remembered when pause interrupts.
  always_comb begin
    run_next = st;
    if ((st == S_COUNTIN) && tick && (cin_cnt == CIN_LAST)) begin
      run_next = S_PLAY;
    end else if ((st == S_PLAY) && end_pending) begin
      run_next = S_DONE;
    end
  end

  // Playback FSM, divider, step counter and the two-cycle note read pipeline.
  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      st          <= S_IDLE;
      resume_st   <= S_PLAY;
      divider     <= '0;
      step        <= '0;
      cin_cnt     <= '0;
      notes       <= '0;
      note_valid  <= 1'b0;
      rd_pending  <= 1'b0;
      end_pending <= 1'b0;
      song_done   <= 1'b0;
    end else if (stop) begin
      // Abort: any read in flight is dropped without a valid pulse.
      st          <= S_IDLE;
      resume_st   <= S_PLAY;
      divider     <= '0;
      step        <= '0;
      cin_cnt     <= '0;
      notes       <= '0;
      note_valid  <= 1'b0;
      rd_pending  <= 1'b0;
      end_pending <= 1'b0;
      song_done   <= 1'b0;
    end else begin
      // A read issued on a tick completes the next cycle in any state,
      // including PAUSE, so rest steps (mask 0) still pulse note_valid.
      note_valid <= rd_pending;
      rd_pending <= 1'b0;
      if (rd_pending) begin
        notes <= rom_data;
      end

      case (st)
        S_IDLE, S_DONE: begin
          if (start) begin
            st          <= START_ST;
            divider     <= '0;
            step        <= '0;
            cin_cnt     <= '0;
            end_pending <= 1'b0;
            song_done   <= 1'b0;
          end
        end

        S_COUNTIN, S_PLAY: begin
          if (tick) begin
            divider <= '0;
            if (st == S_COUNTIN) begin
              cin_cnt <= (cin_cnt == CIN_LAST) ? '0 : cin_cnt + 1'b1;
            end else begin
              rd_pending <= 1'b1;
              if (step != STEP_LAST) begin
                step <= step + 1'b1;
              end else if (loop) begin
                step <= '0;
              end else begin
                // Hold the last step; finish once its read has landed.
                end_pending <= 1'b1;
              end
            end
          end else begin
            divider <= divider + 1'b1;
          end

          if (run_next == S_DONE) begin
            st        <= S_DONE;
            song_done <= 1'b1;
          end else if (pause) begin
            st        <= S_PAUSE;
            resume_st <= run_next;
          end else begin
            st <= run_next;
          end
        end

        S_PAUSE: begin
          // Divider, step and count-in counter hold; start is ignored here.
          if (!pause) begin
            st <= resume_st;
          end
        end

        default: begin
          st <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_note_scheduler.sv
// tb_note_scheduler: directed + randomized bench for note_scheduler.
// The reference model tracks playback as "active cycles since start" and a
// queue of expected note arrivals, derived from the step/tick timing rules.
module tb_note_scheduler;

  localparam int TICK_DIV      = 4;
  localparam int STEP_W        = 9;
  localparam int SONG_LEN      = 6;
  localparam int COUNTIN_STEPS = 2;

  logic              clk    = 1'b0;
  logic              resetn = 1'b1;
  logic              start  = 1'b0;
  logic              stop   = 1'b0;
  logic              pause  = 1'b0;
  logic              loop   = 1'b0;
  logic [STEP_W-1:0] rom_addr;
  logic [4:0]        rom_data;
  logic [4:0]        notes;
  logic              note_valid;
  logic [STEP_W-1:0] step;
  logic              tick;
  logic [2:0]        state;
  logic              song_done;

  logic [4:0] rom [0:511];

  int tests = 0;
  int fails = 0;

  // Model state
  int          cyc       = 0;
  bit          m_run     = 1'b0;
  int          m_act     = 0;
  int          m_k       = 0;
  int          m_cin     = 0;
  int          m_done_at = -1;
  bit          m_frz_next = 1'b0;
  logic [STEP_W-1:0] m_step = '0;
  logic [4:0]  m_notes   = '0;
  int          nv_t[$];
  logic [4:0]  nv_m[$];

  // Observation bookkeeping
  bit          last_tick = 1'b0;
  int          nv_seen   = 0;
  int          first_nv  = -1;
  int          tick_cyc[$];

  note_scheduler #(
    .TICK_DIV(TICK_DIV),
    .STEP_W(STEP_W),
    .SONG_LEN(SONG_LEN),
    .COUNTIN_STEPS(COUNTIN_STEPS)
  ) dut (
    .CLOCK_50(clk),
    .resetn(resetn),
    .start(start),
    .stop(stop),
    .pause(pause),
    .loop(loop),
    .rom_addr(rom_addr),
    .rom_data(rom_data),
    .notes(notes),
    .note_valid(note_valid),
    .step(step),
    .tick(tick),
    .state(state),
    .song_done(song_done)
  );

  always #5 clk = ~clk;

  // Synchronous chart ROM: one cycle of read latency.
  always @(posedge clk) rom_data <= rom[rom_addr];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h cyc=%0d", tag, obs, exp, cyc);
    end
  endtask

  task automatic model_clear();
    m_run      = 1'b0;
    m_act      = 0;
    m_k        = 0;
    m_cin      = 0;
    m_done_at  = -1;
    m_frz_next = 1'b0;
    m_step     = '0;
    m_notes    = '0;
    nv_t.delete();
    nv_m.delete();
  endtask

  // One clock cycle: check outputs at the falling edge, advance the model
  // with the inputs applied this cycle, then step past the rising edge.
  task automatic do_cycle();
    bit         frz;
    bit         exp_tick;
    bit         exp_nv;
    logic [2:0] exp_state;
    @(negedge clk);
    frz      = m_frz_next;
    exp_tick = 1'b0;
    if (m_run && !frz) begin
      m_act++;
      exp_tick = (m_act % TICK_DIV == 0);
    end
    exp_nv = (nv_t.size() > 0) && (nv_t[0] == cyc);
    if (exp_nv) begin
      m_notes = nv_m.pop_front();
      void'(nv_t.pop_front());
    end
    if (m_done_at >= 0 && cyc >= m_done_at)  exp_state = 3'd4;
    else if (frz)                            exp_state = 3'd3;
    else if (m_run && m_cin > 0)             exp_state = 3'd1;
    else if (m_run || m_done_at >= 0)        exp_state = 3'd2;
    else                                     exp_state = 3'd0;

    chk("tick", tick, exp_tick);
    chk("note_valid", note_valid, exp_nv);
    chk("notes", notes, m_notes);
    chk("step", step, m_step);
    chk("rom_addr", rom_addr, m_step);
    chk("state", state, exp_state);
    chk("song_done", song_done, exp_state == 3'd4);

    last_tick = tick;
    if (tick) tick_cyc.push_back(cyc);
    if (note_valid) begin
      nv_seen++;
      if (first_nv < 0) first_nv = cyc;
    end

    if (exp_tick) begin
      if (m_cin > 0) begin
        m_cin--;
      end else begin
        nv_t.push_back(cyc + 2);
        nv_m.push_back(rom[m_k % SONG_LEN]);
        m_k++;
        if ((m_k % SONG_LEN == 0) && !loop) begin
          m_run     = 1'b0;
          m_done_at = cyc + 2;
        end else begin
          m_step = STEP_W'(m_k % SONG_LEN);
        end
      end
    end

    if (stop) begin
      model_clear();
    end else begin
      m_frz_next = m_run && pause;
      if (start && !m_run && !(m_done_at >= 0 && cyc < m_done_at)) begin
        m_run     = 1'b1;
        m_act     = 0;
        m_k       = 0;
        m_step    = '0;
        m_done_at = -1;
`ifdef COUNTIN_EN
        m_cin = COUNTIN_STEPS;
`else
        m_cin = 0;
`endif
      end
    end

    @(posedge clk);
    #1;
    cyc++;
    start = 1'b0;
    stop  = 1'b0;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) do_cycle();
  endtask

  task automatic wait_tick(input int budget);
    last_tick = 1'b0;
    for (int i = 0; i < budget && !last_tick; i++) do_cycle();
    chk("wait_tick_timeout", last_tick, 1'b1);
  endtask

  task automatic run_until_nv(input int n, input int budget);
    for (int i = 0; i < budget && nv_seen < n; i++) do_cycle();
    chk("wait_nv_timeout", nv_seen >= n, 1'b1);
  endtask

  initial begin
    int   pause_left;
    int   rel_gap;
    logic [STEP_W-1:0] frozen_step;
    int   nv_before;

    for (int i = 0; i < 512; i++) rom[i] = 5'(i + 1);

    // Reset values, asynchronously applied
    #1 resetn = 1'b0;
    #1;
    chk("rst_state", state, 3'd0);
    chk("rst_step", step, 0);
    chk("rst_notes", notes, 0);
    chk("rst_note_valid", note_valid, 0);
    chk("rst_tick", tick, 0);
    chk("rst_song_done", song_done, 0);
    @(posedge clk);
    @(posedge clk);
    #1 resetn = 1'b1;
    model_clear();
    run(3);

    // Full song, no loop: notes 1..6 then DONE with notes held
    loop  = 1'b0;
    start = 1'b1;
    run(31);
    chk("done_state", state, 3'd4);
    chk("done_flag", song_done, 1'b1);
    chk("done_notes", notes, 5'd6);
    run(5);
    chk("done_notes_held", notes, 5'd6);

    // Restart from DONE with loop: 7th note wraps back to ROM[0]
    loop    = 1'b1;
    start   = 1'b1;
    nv_seen = 0;
    run_until_nv(7, 60);
    chk("loop_7th_notes", notes, 5'd1);
    chk("loop_not_done", song_done, 1'b0);

    // Pause held 10 cycles from the cycle after a tick
    wait_tick(10);
    frozen_step = step;
    nv_before   = nv_seen;
    pause = 1'b1;
    run(10);
    pause = 1'b0;
    chk("pause_nv_fired", nv_seen - nv_before, 1);
    chk("pause_step_frozen", step, frozen_step);
    chk("pause_state", state, 3'd3);
    rel_gap = -1;
    for (int i = 0; i < 8 && rel_gap < 0; i++) begin
      do_cycle();
      if (last_tick) rel_gap = i;
    end
    chk("pause_release_gap", rel_gap, 3);

    // Stop in the cycle after a tick discards that read
    wait_tick(10);
    stop = 1'b1;
    do_cycle();
    chk("stop_state", state, 3'd0);
    chk("stop_notes", notes, 0);
    chk("stop_step", step, 0);
    chk("stop_no_nv", note_valid, 1'b0);
    run(2);
    start   = 1'b1;
    nv_seen = 0;
    run_until_nv(1, 20);
    chk("replay_first_notes", notes, 5'd1);

    // Asynchronous reset mid-play at step 3
    for (int i = 0; i < 40 && !(step == 3 && state == 3'd2); i++) do_cycle();
    chk("reach_step3", step, 3);
    #1 resetn = 1'b0;
    #1;
    chk("mrst_state", state, 3'd0);
    chk("mrst_step", step, 0);
    chk("mrst_notes", notes, 0);
    chk("mrst_tick", tick, 0);
    chk("mrst_note_valid", note_valid, 0);
    chk("mrst_song_done", song_done, 0);
    model_clear();
    @(posedge clk);
    #1 resetn = 1'b1;
    cyc++;
    tick_cyc.delete();
    run(12);
    chk("mrst_no_tick", tick_cyc.size(), 0);

    // Randomized chart, pauses, stray starts and stops
    for (int i = 0; i < 512; i++) rom[i] = 5'($urandom_range(0, 31));
    loop       = 1'b1;
    start      = 1'b1;
    pause_left = 0;
    for (int i = 0; i < 700; i++) begin
      if (pause_left > 0) begin
        pause = 1'b1;
        pause_left--;
      end else begin
        pause = 1'b0;
        if (m_run && $urandom_range(0, 19) == 0) pause_left = $urandom_range(1, 6);
      end
      if (!m_run) start = ($urandom_range(0, 3) == 0);
      else        start = ($urandom_range(0, 49) == 0);
      stop = ($urandom_range(0, 149) == 0);
      do_cycle();
    end
    pause = 1'b0;
    do_cycle();
    loop = 1'b0;
    if (!m_run) start = 1'b1;
    run(40);
    chk("rand_end_done", song_done, 1'b1);

`ifdef COUNTIN_EN
    // Count-in: two silent ticks, first chart note 4+2 cycles after the last
    stop = 1'b1;
    do_cycle();
    for (int i = 0; i < 8; i++) rom[i] = 5'(i + 1);
    tick_cyc.delete();
    first_nv = -1;
    start    = 1'b1;
    run(20);
    chk("cin_first_notes_seen", first_nv >= 0, 1'b1);
    chk("cin_ticks_before_nv", (tick_cyc.size() >= 2) && (tick_cyc[1] < first_nv), 1'b1);
    if (tick_cyc.size() >= 2) chk("cin_latency", first_nv - tick_cyc[1], 6);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
